// File: rtl/pipe_alu_collector.sv
// pipe_alu_collector
//
// Receive-side companion to the pipelined ALU. Every op accepted by the
// issuer travels down a {valid, opcode, tag} delay line that matches the
// ALU latency. When the last stage is valid, alu_out holds that op's result,
// and the result is written into a small FIFO together with its opcode and
// tag. A downstream consumer drains the FIFO over a valid/ready handshake.
// Credits (FIFO entries plus ops in flight) gate issue_ready, so a captured
// result always has a free FIFO slot.
//
// Optional feature macro: PIPE_ALU_COLLECT_FLAGS_EN
//   When defined, res_zero / res_neg flags are computed at capture time and
//   stored in the FIFO alongside each result.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous, active-high reset
//   issue_valid   issuer presents an op this cycle
//   issue_ready   credit available; op is tracked when valid & ready
//   issue_opcode  opcode sent to the ALU with this issue
//   issue_tag     issuer tag carried with the op
//   alu_out       ALU result bus
//   res_valid     FIFO head holds a result
//   res_ready     consumer accepts the head entry
//   res_data      result at FIFO head
//   res_opcode    opcode at FIFO head
//   res_tag       tag at FIFO head
//   occupancy     FIFO entries plus ops in flight
//   res_zero      (flags build) stored res_data == 0
//   res_neg       (flags build) stored res_data MSB

module pipe_alu_collector #(
    parameter int WIDTH   = 4,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_valid,
    output logic                     issue_ready,
    input  logic [2:0]               issue_opcode,
    input  logic [TAG_W-1:0]         issue_tag,
    input  logic [WIDTH-1:0]         alu_out,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [WIDTH-1:0]         res_data,
    output logic [2:0]               res_opcode,
    output logic [TAG_W-1:0]         res_tag,
    output logic [$clog2(DEPTH):0]   occupancy
`ifdef PIPE_ALU_COLLECT_FLAGS_EN
    ,
    output logic                     res_zero,
    output logic                     res_neg
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Delay line tracking ops inside the ALU pipeline
    logic [LATENCY-1:0] r_dl_valid;
    logic [2:0]         r_dl_op  [LATENCY];
    logic [TAG_W-1:0]   r_dl_tag [LATENCY];

    // Result FIFO
    logic [WIDTH-1:0]   r_mem_data [DEPTH];
    logic [2:0]         r_mem_op   [DEPTH];
    logic [TAG_W-1:0]   r_mem_tag  [DEPTH];
`ifdef PIPE_ALU_COLLECT_FLAGS_EN
    logic               r_mem_zero [DEPTH];
    logic               r_mem_neg  [DEPTH];
`endif
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;

    logic               w_fire;
    logic               w_push;
    logic               w_pop;
    int                 w_inflight;

    assign w_fire = issue_valid & issue_ready;
    assign w_push = r_dl_valid[LATENCY-1];
    assign w_pop  = res_valid & res_ready;

    always_comb begin
        w_inflight = 0;
        for (int i = 0; i < LATENCY; i++) begin
            w_inflight += int'(r_dl_valid[i]);
        end
    end

    // Credit ensures inflight never exceeds DEPTH, so the cast cannot truncate.
    assign occupancy   = r_count + CW'(w_inflight);
    // Deliberately uses registered state only: a pop this cycle frees its
    // credit one cycle later.
    assign issue_ready = (occupancy < DEPTH_C);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dl_valid <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_dl_op[i]  <= '0;
                r_dl_tag[i] <= '0;
            end
        end else begin
            r_dl_valid[0] <= w_fire;
            r_dl_op[0]    <= issue_opcode;
            r_dl_tag[0]   <= issue_tag;
            for (int i = 1; i < LATENCY; i++) begin
                r_dl_valid[i] <= r_dl_valid[i-1];
                r_dl_op[i]    <= r_dl_op[i-1];
                r_dl_tag[i]   <= r_dl_tag[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            // Entries are cleared so the head reads 0 straight out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_data[i] <= '0;
                r_mem_op[i]   <= '0;
                r_mem_tag[i]  <= '0;
`ifdef PIPE_ALU_COLLECT_FLAGS_EN
                r_mem_zero[i] <= 1'b0;
                r_mem_neg[i]  <= 1'b0;
`endif
            end
        end else begin
            if (w_push) begin
                r_mem_data[r_wr_ptr] <= alu_out;
                r_mem_op[r_wr_ptr]   <= r_dl_op[LATENCY-1];
                r_mem_tag[r_wr_ptr]  <= r_dl_tag[LATENCY-1];
`ifdef PIPE_ALU_COLLECT_FLAGS_EN
                r_mem_zero[r_wr_ptr] <= (alu_out == '0);
                r_mem_neg[r_wr_ptr]  <= alu_out[WIDTH-1];
`endif
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign res_valid  = (r_count != '0);
    assign res_data   = r_mem_data[r_rd_ptr];
    assign res_opcode = r_mem_op[r_rd_ptr];
    assign res_tag    = r_mem_tag[r_rd_ptr];
`ifdef PIPE_ALU_COLLECT_FLAGS_EN
    assign res_zero   = r_mem_zero[r_rd_ptr];
    assign res_neg    = r_mem_neg[r_rd_ptr];
`endif

endmodule

// File: tb/tb_pipe_alu_collector.sv
// Testbench for pipe_alu_collector (LATENCY=2, DEPTH=4).
// A two-stage a+b model stands in for the ALU. The stimulus driver pushes
// the expected result for every accepted issue into a queue; the negedge
// monitor compares occupancy/credit against the queue size and pops/compares
// every result the consumer accepts.

module tb_pipe_alu_collector;

    localparam int WIDTH = 4;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam int TAG_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             issue_valid = 1'b0;
    logic             issue_ready;
    logic [2:0]       issue_opcode = '0;
    logic [TAG_W-1:0] issue_tag = '0;
    logic [WIDTH-1:0] alu_out;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [WIDTH-1:0] res_data;
    logic [2:0]       res_opcode;
    logic [TAG_W-1:0] res_tag;
    logic [2:0]       occupancy;
`ifdef PIPE_ALU_COLLECT_FLAGS_EN
    logic             res_zero;
    logic             res_neg;
`endif

    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic [WIDTH-1:0] alu_p1 = '0;
    logic [WIDTH-1:0] alu_p2 = '0;

    pipe_alu_collector #(
        .WIDTH(WIDTH), .LATENCY(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .issue_valid(issue_valid),
        .issue_ready(issue_ready),
        .issue_opcode(issue_opcode),
        .issue_tag(issue_tag),
        .alu_out(alu_out),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data(res_data),
        .res_opcode(res_opcode),
        .res_tag(res_tag),
        .occupancy(occupancy)
`ifdef PIPE_ALU_COLLECT_FLAGS_EN
        ,
        .res_zero(res_zero),
        .res_neg(res_neg)
`endif
    );

    always #5 clk = ~clk;

    // ALU stand-in: result of operands sampled at edge k is on alu_out
    // during the cycle after edge k+1.
    always @(posedge clk) begin
        alu_p1 <= WIDTH'(a + b);
        alu_p2 <= alu_p1;
    end
    assign alu_out = alu_p2;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic [2:0]       op;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t pend;
    bit   pend_valid = 0;
    exp_t mon_e;
    bit   mon_en = 0;
    int   checks = 0;
    int   errors = 0;
    int   fires = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && mon_en) begin
            chk("occupancy", int'(occupancy), exp_q.size());
            chk("issue_ready", int'(issue_ready), int'(exp_q.size() < DEPTH));
            if (exp_q.size() == 0) begin
                chk("res_valid_when_empty", int'(res_valid), 0);
            end else if (res_valid && res_ready) begin
                mon_e = exp_q.pop_front();
                chk("res_data", int'(res_data), int'(mon_e.d));
                chk("res_opcode", int'(res_opcode), int'(mon_e.op));
                chk("res_tag", int'(res_tag), int'(mon_e.tag));
`ifdef PIPE_ALU_COLLECT_FLAGS_EN
                chk("res_zero", int'(res_zero), int'(mon_e.d == 0));
                chk("res_neg", int'(res_neg), int'(mon_e.d[WIDTH-1]));
`endif
            end
        end
    end

    // One clock cycle of stimulus. The expectation for an accepted op is
    // queued just after the edge that accepts it.
    task automatic step(input bit v, input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                        input logic [2:0] op, input logic [TAG_W-1:0] tg, input bit rr);
        @(posedge clk);
        #1;
        if (pend_valid) begin
            exp_q.push_back(pend);
            pend_valid = 0;
        end
        issue_valid  = v;
        a            = ia;
        b            = ib;
        issue_opcode = op;
        issue_tag    = tg;
        res_ready    = rr;
        #2;
        if (issue_valid && issue_ready) begin
            pend.d     = WIDTH'(ia + ib);
            pend.op    = op;
            pend.tag   = tg;
            pend_valid = 1;
            fires++;
        end
    endtask

    task automatic idle(input int n, input bit rr);
        for (int i = 0; i < n; i++) step(0, '0, '0, '0, '0, rr);
    endtask

    // Reset asserted mid-cycle; outputs must clear without waiting for a clock.
    task automatic mid_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        issue_valid = 1'b0;
        res_ready = 1'b0;
        #1;
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_occupancy", int'(occupancy), 0);
        chk("rst_issue_ready", int'(issue_ready), 1);
        exp_q.delete();
        pend_valid = 0;
        @(negedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        int k;
        int f0;

        // 1. Reset
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("init_res_valid", int'(res_valid), 0);
        chk("init_res_data", int'(res_data), 0);
        chk("init_res_opcode", int'(res_opcode), 0);
        chk("init_res_tag", int'(res_tag), 0);
        chk("init_occupancy", int'(occupancy), 0);
        chk("init_issue_ready", int'(issue_ready), 1);
        mon_en = 1;
        idle(3, 1);
        @(negedge clk);
        chk("post_rst_res_valid", int'(res_valid), 0);
        chk("post_rst_res_data", int'(res_data), 0);

        // 2. Single op: result visible in the third cycle after issue
        step(1, 4'b1010, 4'b0101, 3'b000, 2'd1, 1);
        k = 1;
        while (k <= 10) begin
            step(0, '0, '0, '0, '0, 1);
            @(negedge clk);
            if (res_valid) break;
            k++;
        end
        chk("single_latency_cycles", k, 3);
        chk("single_res_data", int'(res_data), 15);
        chk("single_res_tag", int'(res_tag), 1);
        idle(2, 1);

        // 3. Backpressure: only DEPTH issues accepted
        f0 = fires;
        for (int i = 0; i < 8; i++) step(1, 4'($urandom), 4'($urandom), 3'($urandom), 2'(i), 0);
        @(negedge clk);
        chk("bp_accepted", fires - f0, 4);
        chk("bp_issue_ready", int'(issue_ready), 0);
        chk("bp_occupancy", int'(occupancy), 4);

        // 4. One pop at full, then a refill behind tag 3
        f0 = fires;
        step(1, 4'b1000, 4'b1001, 3'b010, 2'd0, 1);
        @(negedge clk);
        chk("refill_ready_same_cycle", int'(issue_ready), 0);
        step(1, 4'b1000, 4'b1001, 3'b010, 2'd0, 0);
        chk("refill_accepted", fires - f0, 1);
        idle(3, 0);
        idle(8, 1);

        // 5. Streaming with consumer always ready
        f0 = fires;
        for (int i = 0; i < 10; i++) step(1, 4'($urandom), 4'($urandom), 3'($urandom), 2'(i % 4), 1);
        chk("stream_accepted", fires - f0, 10);
        idle(6, 1);

        // 6. Reset with ops in flight
        step(1, 4'd3, 4'd4, 3'b001, 2'd2, 1);
        step(1, 4'd5, 4'd6, 3'b011, 2'd3, 1);
        mid_reset();
        idle(6, 1);
        step(1, 4'b0100, 4'b1011, 3'b101, 2'd1, 1);
        idle(4, 1);
`ifdef PIPE_ALU_COLLECT_FLAGS_EN
        step(1, 4'b1000, 4'b1000, 3'b110, 2'd2, 1);
        idle(4, 1);
`endif

        // Randomized traffic with random consumer stalls
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom), 3'($urandom), 2'($urandom),
                 ($urandom_range(0, 2) != 0));
        end

        k = 0;
        while ((exp_q.size() != 0 || pend_valid) && k < 50) begin
            step(0, '0, '0, '0, '0, 1);
            k++;
        end
        @(negedge clk);
        chk("drain_left", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
